ram_sum_checker: RTL and testbench

- Read-side controller for the 256x5 synchronous sum-table RAM (CS/WE/addr/dataIn/dataOut interface). The table is written with A+B at address {A,B}.
- Sweeps an inclusive address range with back-to-back reads and streams each returned word out.
- Compares each word against the expected sum addr[7:4]+addr[3:0], then reports the mismatch count and the first failing address.
- Sits beside the write path, sharing the RAM through a mux that the write side leaves with CS low while this block is busy.

---
 rtl/ram_sum_checker.sv | 203 ++++++++++++++++++++
 tb/tb_ram_sum_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_sum_checker.sv
// ram_sum_checker
//   Read-side controller for the sum-table RAM. Each table word at address
//   {A,B} should hold A+B. On an accepted start the block sweeps the inclusive
//   range addr_lo..addr_hi with back-to-back reads, streams every returned word
//   out, and compares it with the expected sum. Mismatches are counted and the
//   first failing address is kept.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   start          begin a sweep (honoured only when idle)
//   abort          stop a sweep and return to idle without a done pulse
//   addr_lo        first address of the sweep, captured on an accepted start
//   addr_hi        last address (inclusive), captured on an accepted start
//   ram_cs         RAM chip select
//   ram_we         RAM write enable, always 0
//   ram_addr       RAM read address
//   ram_dout       RAM read data, valid the cycle after a read edge
//   busy           high from the cycle after an accepted start until done
//   rd_valid       rd_addr/rd_data are meaningful this cycle
//   rd_addr        address of the streamed word
//   rd_data        word returned by the RAM
//   done           one-cycle pulse at the end of a sweep
//   err_count      mismatches seen in the last sweep
//   err_flag       err_count != 0
//   first_err_addr address of the first mismatch, 0 if none
module ram_sum_checker #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] addr_lo,
    input  logic [ADDR_W-1:0] addr_hi,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic [ADDR_W:0]   err_count,
    output logic              err_flag,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int HALF_W = ADDR_W / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // Expected table contents: sum of the upper and lower address halves,
    // zero-extended first so the carry lands in the top data bit.
    function automatic logic [DATA_W-1:0] exp_sum(input logic [ADDR_W-1:0] a);
        exp_sum = DATA_W'({1'b0, a[ADDR_W-1:HALF_W]}) + DATA_W'({1'b0, a[HALF_W-1:0]});
    endfunction

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   ptr_r, ptr_s;
    logic [ADDR_W-1:0]   hi_r, hi_s;
    logic                cs_r;
    logic                busy_r;
    logic                done_r;
    logic                tag_valid_r, tag_valid_s;
    logic [ADDR_W-1:0]   tag_addr_r, tag_addr_s;
    logic [ADDR_W:0]     err_cnt_r, err_cnt_s;
    logic                err_flag_r;
    logic [ADDR_W-1:0]   first_err_r, first_err_s;
    logic                mismatch_s;

    // Next-state, pointer, compare tag and error bookkeeping.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        hi_s        = hi_r;
        tag_valid_s = 1'b0;
        tag_addr_s  = tag_addr_r;
        err_cnt_s   = err_cnt_r;
        first_err_s = first_err_r;
        mismatch_s  = 1'b0;

        // The word tagged last cycle is on ram_dout now; check it.
        if (tag_valid_r) begin
            mismatch_s = (ram_dout != exp_sum(tag_addr_r));
        end else begin
            mismatch_s = 1'b0;
        end

        if (mismatch_s) begin
            err_cnt_s = err_cnt_r + {{ADDR_W{1'b0}}, 1'b1};
            if (err_cnt_r == {(ADDR_W+1){1'b0}}) begin
                first_err_s = tag_addr_r;
            end else begin
                first_err_s = first_err_r;
            end
        end else begin
            err_cnt_s   = err_cnt_r;
            first_err_s = first_err_r;
        end

        case (state_r)
            ST_IDLE: begin
                // abort beats start; a dropped start leaves everything as is.
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (start) begin
                    ptr_s       = addr_lo;
                    hi_s        = addr_hi;
                    err_cnt_s   = {(ADDR_W+1){1'b0}};
                    first_err_s = {ADDR_W{1'b0}};
                    if (addr_lo <= addr_hi) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_FIN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // Read issued this cycle is never tagged, so it is dropped.
                    state_s = ST_IDLE;
                end else begin
                    tag_valid_s = 1'b1;
                    tag_addr_s  = ptr_r;
                    // Stop on hi rather than wrapping, so hi = all-ones is safe.
                    if (ptr_r == hi_r) begin
                        state_s = ST_DRAIN;
                    end else begin
                        ptr_s = ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FIN;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; outputs are decoded from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {ADDR_W{1'b0}};
            hi_r        <= {ADDR_W{1'b0}};
            cs_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            tag_valid_r <= 1'b0;
            tag_addr_r  <= {ADDR_W{1'b0}};
            err_cnt_r   <= {(ADDR_W+1){1'b0}};
            err_flag_r  <= 1'b0;
            first_err_r <= {ADDR_W{1'b0}};
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            hi_r        <= hi_s;
            cs_r        <= (state_s == ST_RUN);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= (state_s == ST_FIN);
            tag_valid_r <= tag_valid_s;
            tag_addr_r  <= tag_addr_s;
            err_cnt_r   <= err_cnt_s;
            err_flag_r  <= (err_cnt_s != {(ADDR_W+1){1'b0}});
            first_err_r <= first_err_s;
        end
    end

    assign ram_cs         = cs_r;
    assign ram_we         = 1'b0;
    assign ram_addr       = ptr_r;
    assign busy           = busy_r;
    assign rd_valid       = tag_valid_r;
    assign rd_addr        = tag_addr_r;
    // RAM data only exists in the tagged cycle, so it is passed straight
    // through, gated to zero when nothing is being streamed.
    assign rd_data        = tag_valid_r ? ram_dout : {DATA_W{1'b0}};
    assign done           = done_r;
    assign err_count      = err_cnt_r;
    assign err_flag       = err_flag_r;
    assign first_err_addr = first_err_r;

endmodule

// File: tb/tb_ram_sum_checker.sv
// Directed bench for ram_sum_checker with a behavioural 256x5 RAM and a
// write-side port sharing it through a mux.
module tb_ram_sum_checker;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [7:0]  addr_lo, addr_hi;
    logic        ram_cs, ram_we;
    logic [7:0]  ram_addr;
    logic [4:0]  ram_dout;
    logic        busy, rd_valid, done, err_flag;
    logic [7:0]  rd_addr, first_err_addr;
    logic [4:0]  rd_data;
    logic [8:0]  err_count;

    logic        wr_cs, wr_we;
    logic [7:0]  wr_addr;
    logic [4:0]  wr_din;
    logic        m_cs, m_we;
    logic [7:0]  m_addr;
    logic [4:0]  mem [0:255];
    logic [4:0]  img [0:255];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_sum_checker #(.ADDR_W(8), .DATA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .addr_lo(addr_lo), .addr_hi(addr_hi),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .busy(busy), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
        .done(done), .err_count(err_count), .err_flag(err_flag),
        .first_err_addr(first_err_addr)
    );

    // RAM sharing: the checker owns the RAM whenever it drives CS.
    assign m_cs   = ram_cs | wr_cs;
    assign m_we   = ram_cs ? ram_we : wr_we;
    assign m_addr = ram_cs ? ram_addr : wr_addr;

    // Synchronous RAM model.
    always @(posedge clk) begin
        if (m_cs) begin
            if (m_we) mem[m_addr] <= wr_din;
            else      ram_dout    <= mem[m_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ram_write(input logic [7:0] a, input logic [4:0] d);
        wr_cs = 1'b1; wr_we = 1'b1; wr_addr = a; wr_din = d;
        img[a] = d;
        tick();
        wr_cs = 1'b0; wr_we = 1'b0;
    endtask

    // Run one sweep and check stream, chip select, busy, done timing and result.
    task automatic sweep(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                         input int n, input int exp_done, input int exp_err,
                         input logic [7:0] exp_first, input int inj);
        int c, done_cyc, beats, cs_cnt, cs_bad, rd_bad, busy_bad;
        logic [7:0] ea;
        done_cyc = -1; beats = 0; cs_cnt = 0; cs_bad = 0; rd_bad = 0; busy_bad = 0;
        start = 1'b1; addr_lo = lo; addr_hi = hi;
        tick();
        start = 1'b0;
        c = 1;
        while (c <= exp_done + 20 && done_cyc < 0) begin
            if (c == inj) begin
                start = 1'b1; addr_lo = 8'h00; addr_hi = 8'h01;
            end else begin
                start = 1'b0; addr_lo = lo; addr_hi = hi;
            end
            if (ram_we !== 1'b0) cs_bad++;
            if (ram_cs === 1'b1) begin
                cs_cnt++;
                ea = lo + 8'(c - 1);
                if (c < 1 || c > n || ram_addr !== ea) cs_bad++;
            end
            if (rd_valid === 1'b1) begin
                ea = lo + 8'(beats);
                if (c < 2 || c > n + 1 || rd_addr !== ea || rd_data !== img[ea]) rd_bad++;
                if (rd_addr == 8'hFF) chk({tag, "_data_ff"}, 32'(rd_data), 32'd30);
                if (rd_addr == 8'h35) chk({tag, "_data_35"}, 32'(rd_data), 32'd8);
                if (rd_addr == 8'h4A) chk({tag, "_data_4a"}, 32'(rd_data), 32'd14);
                beats++;
            end
            if (busy !== (c <= exp_done)) busy_bad++;
            if (done === 1'b1) done_cyc = c;
            tick();
            c++;
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, done_cyc, exp_done);
        chk({tag, "_beats"}, beats, n);
        chk({tag, "_cs_cycles"}, cs_cnt, n);
        chk({tag, "_cs_bad"}, cs_bad, 0);
        chk({tag, "_rd_bad"}, rd_bad, 0);
        chk({tag, "_busy_bad"}, busy_bad, 0);
        chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), exp_err);
        chk({tag, "_err_flag"}, 32'(err_flag), (exp_err != 0) ? 32'd1 : 32'd0);
        chk({tag, "_first_err"}, 32'(first_err_addr), 32'(exp_first));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ram_cs"}, 32'(ram_cs), 32'd0);
        chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err_count"}, 32'(err_count), 32'd0);
        chk({tag, "_err_flag"}, 32'(err_flag), 32'd0);
        chk({tag, "_first_err"}, 32'(first_err_addr), 32'd0);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; addr_lo = 8'h00; addr_hi = 8'h00;
        wr_cs = 1'b0; wr_we = 1'b0; wr_addr = 8'h00; wr_din = 5'd0;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // Fill the table with correct sums through the write side.
        for (int a = 0; a < 256; a++) begin
            ram_write(8'(a), 5'((a >> 4) + (a & 15)));
        end

        // Full clean sweep: 256 beats, done in cycle 258.
        sweep("full", 8'h00, 8'hFF, 256, 258, 0, 8'h00, 0);

        // Two corrupted words; first in sweep order is 0x28.
        ram_write(8'h96, 5'd0);
        ram_write(8'h28, 5'd3);
        sweep("errs", 8'h00, 8'hFF, 256, 258, 2, 8'h28, 0);
        repeat (3) tick();
        chk("hold_err_count", 32'(err_count), 32'd2);
        chk("hold_err_flag", 32'(err_flag), 32'd1);
        chk("hold_first_err", 32'(first_err_addr), 32'h28);

        // Empty sweep clears the previous result and never touches the RAM.
        sweep("empty", 8'h10, 8'h05, 0, 1, 0, 8'h00, 0);

        // Single-word sweep.
        sweep("single", 8'h4A, 8'h4A, 1, 3, 0, 8'h00, 0);

        // Top of the address space with a start pulsed mid-sweep.
        sweep("top", 8'hF0, 8'hFF, 16, 18, 0, 8'h00, 6);

        // Abort in the 5th RUN cycle with a bad word already compared at 0x02.
        ram_write(8'h02, 5'd0);
        start = 1'b1; addr_lo = 8'h00; addr_hi = 8'h3F;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("abort_c5_rd_valid", 32'(rd_valid), 32'd1);
        chk("abort_c5_rd_addr", 32'(rd_addr), 32'h03);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ram_cs", 32'(ram_cs), 32'd0);
        chk("abort_rd_valid", 32'(rd_valid), 32'd0);
        chk("abort_err_count", 32'(err_count), 32'd1);
        chk("abort_err_flag", 32'(err_flag), 32'd1);
        chk("abort_first_err", 32'(first_err_addr), 32'h02);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (done !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0 || ram_cs !== 1'b0) bad++;
            tick();
        end
        chk("abort_quiet", bad, 0);

        // Reset mid-sweep, after the 0x02 mismatch has been counted.
        start = 1'b1; addr_lo = 8'h00; addr_hi = 8'hFF;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("pre_rst_err_count", 32'(err_count), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_zero("midrst");
        tick();
        chk("midrst_idle_busy", 32'(busy), 32'd0);
        sweep("after_rst", 8'h40, 8'h4F, 16, 18, 0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
